// File: rtl/cronometro_pkg.sv
// Shared constants for the stopwatch display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package cronometro_pkg;

  localparam int NUM_DIGITS = 5;

  localparam logic [6:0] MIN_MAX = 7'd9;
  localparam logic [6:0] SEG_MAX = 7'd59;
  localparam logic [6:0] CEN_MAX = 7'd99;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [4:0] AN_OFF  = 5'b11111;

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_OFF;
    endcase
  endfunction

  function automatic logic [6:0] sat7(
    input logic [6:0] v,
    input logic [6:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/bcd_2dig.sv
// Binary 0-99 to two BCD digits.
// Pure combinational; callers keep the input in range.
module bcd_2dig (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  always_comb begin
    tens = '0;
    for (int i = 1; i < 10; i++) begin
      if (bin >= 7'(10 * i)) tens = 4'(i);
    end
    units = 4'(bin - 7'(tens) * 7'd10);
  end

endmodule

// File: rtl/display_cronometro.sv
// Five-digit multiplexed 7-segment driver, M.SS.CC.
// Snapshot taken once per frame so a frame never tears.
module display_cronometro
  import cronometro_pkg::*;
#(
  parameter int CLK_FREQ     = 25_000_000,
  parameter int SCAN_DIV     = CLK_FREQ / 5000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_timer,
  input  logic       enable_display,
  input  logic       hold,
  input  logic [3:0] minutos,
  input  logic [5:0] segundos,
  input  logic [6:0] centesimas,
  output logic [6:0] seg,
  output logic       dp,
  output logic [4:0] an
);

  localparam int PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST =
    PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK =
    PW'(BLANK_CYCLES);
  localparam logic [2:0] LAST_IDX =
    3'(NUM_DIGITS - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [3:0]    snap_min;
  logic [5:0]    snap_seg;
  logic [6:0]    snap_cen;

  logic [3:0] sec_t, sec_u;
  logic [3:0] cen_t, cen_u;

  bcd_2dig u_sec (
    .bin   ({1'b0, snap_seg}),
    .tens  (sec_t),
    .units (sec_u)
  );

  bcd_2dig u_cen (
    .bin   (snap_cen),
    .tens  (cen_t),
    .units (cen_u)
  );

  logic [3:0] digit;
  logic [4:0] an_d;
  logic       dp_d;
  logic [6:0] seg_d;
  logic       wrap;
  logic       lit;

  assign wrap  = (presc == LAST);
  assign lit   = (presc >= BLANK);
  assign seg_d = seg7(digit);

  // idx0 is the leftmost digit, wired to an[4]
  always_comb begin
    digit = '0;
    an_d  = AN_OFF;
    dp_d  = 1'b1;
    case (idx)
      3'd0: begin
        digit   = snap_min;
        an_d[4] = 1'b0;
        dp_d    = 1'b0;
      end
      3'd1: begin
        digit   = sec_t;
        an_d[3] = 1'b0;
      end
      3'd2: begin
        digit   = sec_u;
        an_d[2] = 1'b0;
        dp_d    = 1'b0;
      end
      3'd3: begin
        digit   = cen_t;
        an_d[1] = 1'b0;
      end
      3'd4: begin
        digit   = cen_u;
        an_d[0] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_timer) begin
      presc    <= '0;
      idx      <= '0;
      snap_min <= '0;
      snap_seg <= '0;
      snap_cen <= '0;
      an       <= AN_OFF;
      seg      <= SEG_OFF;
      dp       <= 1'b1;
    end else if (enable_display) begin
      if (wrap) begin
        presc <= '0;
        idx   <= (idx == LAST_IDX) ?
                 3'd0 : idx + 3'd1;
        if (idx == LAST_IDX && !hold) begin
          snap_min <= 4'(sat7({3'b0, minutos},
                              MIN_MAX));
          snap_seg <= 6'(sat7({1'b0, segundos},
                              SEG_MAX));
          snap_cen <= sat7(centesimas, CEN_MAX);
        end
      end else begin
        presc <= presc + PW'(1);
      end
      if (lit) begin
        an  <= an_d;
        seg <= seg_d;
        dp  <= dp_d;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end else begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end
  end

endmodule
